crypto_frame_packer: RTL
========================

# crypto_frame_packer

Upstream framing stage for `crypto_module`. Takes 32-bit plaintext words from the payload-side AXI-Stream and builds the 128-bit frame `crypto_module` consumes: one key beat, one crypto header beat, then packed plaintext beats, with TLAST on the final beat. It also owns nonce generation, so no two frames get the same IV under one key.

## Interface
Parameters:
- `IN_WIDTH`, 32: input word width; fixed at 32.
- `OUT_WIDTH`, 128: output beat width; fixed at 128.

Ports:
- `clk`  in  1  single clock domain
- `rst_n`  in  1  reset; asynchronous, active-low
- `cfg_key`  in  128  AES key; sampled at frame start
- `cfg_nonce_fixed`  in  64  fixed IV field; sampled at frame start
- `nonce_exhausted`  out  1  message counter used up; no further frames start
- `S_AXIS_TREADY`  out  1  plaintext word accepted
- `S_AXIS_TDATA`  in  32  plaintext word
- `S_AXIS_TLAST`  in  1  last word of message
- `S_AXIS_TVALID`  in  1  word valid
- `M_AXIS_TVALID`  out  1  beat valid
- `M_AXIS_TDATA`  out  128  beat: key, header or plaintext
- `M_AXIS_TLAST`  out  1  last plaintext beat of frame
- `M_AXIS_TREADY`  in  1  `crypto_module` ready

## Operation
- FSM states:
  - IDLE: a frame starts when `S_AXIS_TVALID`=1 and `nonce_exhausted`=0. At start, latch `cfg_key` and `cfg_nonce_fixed`, load the key into the output register, and go to HDR.
  - HDR: when the key beat is consumed, load the header and go to PAYLOAD.
  - PAYLOAD: accept and pack words.
  - FLUSH: the last beat is loaded; wait for it to be consumed, then increment `msg_ctr` and return to IDLE.
- Header beat is {nonce_fixed[63:0], msg_ctr[31:0], 32'h00000001}. The low word is the GCM J0 counter constant.
- Packing of full beats: word 0 goes to [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
- Final partial beat (k<4 words): the words are right-aligned, with the last word in [31:0]. Upper bits are zero. TLAST=1.
- Message of exactly 4n words: the last beat is full and carries TLAST=1. No extra beat is sent.
- Words are never dropped or reordered. Frame length is unbounded.
- `msg_ctr` is 32 bits and resets to 0:
  - It increments once per completed frame.
  - After the frame that used 32'hFFFFFFFF, `nonce_exhausted` sets and stays set until reset. Software must change `cfg_nonce_fixed` after any reset.
- Output register:
  - It reloads only when empty or when being consumed in the same cycle (valid & ready).
  - While `M_AXIS_TVALID`=1 and `M_AXIS_TREADY`=0, M_AXIS_TDATA and M_AXIS_TLAST hold stable.

## Timing
- Reset values: all outputs are 0 (`S_AXIS_TREADY`, `M_AXIS_*`, `nonce_exhausted`). State is IDLE, `msg_ctr`=0, pack buffer empty.
- Reset asserted mid-frame aborts the frame immediately. `msg_ctr` returns to 0 and no TLAST is sent.
- With `M_AXIS_TREADY`=1 throughout, taking start as cycle 0:
  - key beat valid in cycle 1;
  - header beat valid in cycle 2;
  - `S_AXIS_TREADY`=1 from cycle 2;
  - the first full payload beat is valid 4 cycles after the header.
  - Sustained throughput is one word per cycle, i.e. one beat per 4 cycles.
- `S_AXIS_TREADY`=0 in IDLE, HDR and FLUSH.
- In PAYLOAD, `S_AXIS_TREADY`=0 while a completed beat is pending: buffer full and the output register occupied and not being consumed.
- The word carrying `S_AXIS_TLAST` completes the beat in the same cycle, whatever the word count. The state then goes to FLUSH.
- A start request while `nonce_exhausted`=1: the input stays stalled indefinitely and nothing is emitted.

## Structure
- Shared package `crypto_stream_pkg` holds:
  - the width constants (32/128/96/64);
  - J0 constant 32'h00000001;
  - the FSM state encoding.
  - `crypto_module` imports the same widths.
- One sub-module, `axis_out_slice`: a single-entry 128+1-bit output register with valid/ready. The FSM and packer live in the top module.

## Test plan
- Key 128'hee84e19cda87a76291eaaf2054aef812, fixed 64'h13360015f2cb949b, 9 words 32'h00000001..32'h00000009 (TLAST on 9), ready=1. Required beats:
  - key beat;
  - header {13360015f2cb949b, 00000000, 00000001};
  - 128'h00000001_00000002_00000003_00000004;
  - 128'h00000005_00000006_00000007_00000008;
  - 128'h00000000_00000000_00000000_00000009 with TLAST.
- 8-word message → two full beats, TLAST on the second only. `msg_ctr` is 1 in the next header.
- Random `M_AXIS_TREADY` toggling (50%) with a 64-word message → output identical to the ready=1 run. TDATA stays stable while stalled, and `S_AXIS_TREADY` drops when a beat is pending.
- Preload `msg_ctr`=32'hFFFFFFFF by force, send one frame → its header carries FFFFFFFF, `nonce_exhausted`=1 afterwards, and the next frame's first word is never accepted.
- Assert `rst_n`=0 after the header beat of a frame → all outputs 0 in the same cycle. The next frame after release starts with a key beat and `msg_ctr`=0.

Source files
------------

// File: rtl/crypto_stream_pkg.sv
// crypto_stream_pkg: widths, GCM J0 constant and framer state encoding shared with crypto_module
package crypto_stream_pkg;
  localparam int WORD_W = 32;
  localparam int BEAT_W = 128;
  localparam int HI_W = 96;
  localparam int NONCE_W = 64;
  localparam logic [31:0] J0 = 32'h00000001;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, FLUSH} state_t;
endpackage

// File: rtl/crypto_frame_packer_if.sv
// crypto_frame_packer_if: AXI-Stream bundle; master drives data, slave drives ready
interface crypto_frame_packer_if #(parameter int W = 32);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [W-1:0] tdata;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_out_slice.sv
// axis_out_slice: single-entry output register that holds data stable while stalled
module axis_out_slice #(parameter int W = 128) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
endmodule

// File: rtl/crypto_frame_packer.sv
// crypto_frame_packer: emits key beat, nonce header, then right-aligned packed plaintext beats
module crypto_frame_packer
  import crypto_stream_pkg::*;
#(
  parameter int IN_WIDTH = WORD_W,
  parameter int OUT_WIDTH = BEAT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OUT_WIDTH-1:0] cfg_key,
  input  logic [NONCE_W-1:0]   cfg_nonce_fixed,
  output logic                 nonce_exhausted,
  crypto_frame_packer_if.slave  s_axis,
  crypto_frame_packer_if.master m_axis
);
  state_t state;
  logic [NONCE_W-1:0] nonce_r;
  logic [HI_W-1:0] buf_r;
  logic [1:0] cnt;
  logic pend, plast;
  logic [OUT_WIDTH-1:0] pbeat, beat, ld_data;
  logic [31:0] msg_ctr;
  logic ld_valid, ld_last, ld_ready, start, s_fire, m_fire, complete;
  assign s_fire = s_axis.tvalid && s_axis.tready;
  assign m_fire = m_axis.tvalid && m_axis.tready;
  assign start = state == IDLE && s_axis.tvalid && !nonce_exhausted && ld_ready;
  assign complete = s_fire && (cnt == 2'd3 || s_axis.tlast);
  // unused upper lanes of buf_r are kept zero, so a short final beat comes out right-aligned
  assign beat = {buf_r, s_axis.tdata};
  assign s_axis.tready = state == PAYLOAD && !(pend && !ld_ready);
  always_comb begin
    ld_valid = start || state == HDR || pend || complete;
    ld_data = start ? cfg_key : state == HDR ? {nonce_r, msg_ctr, J0} : pend ? pbeat : beat;
    ld_last = start || state == HDR ? 1'b0 : pend ? plast : s_axis.tlast;
  end
  axis_out_slice #(.W(OUT_WIDTH)) u_slice (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(ld_valid),
    .in_data(ld_data),
    .in_last(ld_last),
    .in_ready(ld_ready),
    .out_valid(m_axis.tvalid),
    .out_data(m_axis.tdata),
    .out_last(m_axis.tlast),
    .out_ready(m_axis.tready)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      nonce_r <= '0;
      buf_r <= '0;
      cnt <= 2'd0;
      pend <= 1'b0;
      pbeat <= '0;
      plast <= 1'b0;
      msg_ctr <= '0;
      nonce_exhausted <= 1'b0;
    end else begin
      if (s_fire) begin
        buf_r <= complete ? '0 : {buf_r[HI_W-IN_WIDTH-1:0], s_axis.tdata};
        cnt <= complete ? 2'd0 : cnt + 2'd1;
      end
      // a beat finished while the output register is busy parks here and blocks input
      if (complete && (pend || !ld_ready)) begin
        pend <= 1'b1;
        pbeat <= beat;
        plast <= s_axis.tlast;
      end else if (pend && ld_ready) pend <= 1'b0;
      case (state)
        IDLE: if (start) begin
          nonce_r <= cfg_nonce_fixed;
          state <= HDR;
        end
        HDR: if (ld_ready) state <= PAYLOAD;
        PAYLOAD: if (s_fire && s_axis.tlast) state <= FLUSH;
        FLUSH: if (m_fire && m_axis.tlast) begin
          state <= IDLE;
          msg_ctr <= msg_ctr + 32'd1;
          if (&msg_ctr) nonce_exhausted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
